// File: rtl/aesl_deadlock_pkg.sv
// Shared deadlock-detection types: FSM encodings used by detect and report units.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DL   = 2'd2
  } dl_state_e;

endpackage

// File: rtl/aesl_deadlock_prio_pick.sv
// Lowest-index set bit selector: returns a one-hot vector, or zero for a zero input.
module aesl_deadlock_prio_pick #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot
);

  assign onehot = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/aesl_deadlock_detect_unit.sv
// Per-process deadlock detector: propagates dependency vectors downstream, detects
// a dependency cycle through itself, and holds/forwards the circle report token.
module aesl_deadlock_detect_unit
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned MY_PROC_ID   = 0,
  parameter int unsigned IN_CHAN_NUM  = 1,
  parameter int unsigned OUT_CHAN_NUM = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out
);

  localparam logic [PROC_NUM-1:0] MY_BIT = PROC_NUM'(1) << MY_PROC_ID;

  dl_state_e               r_state;
  dl_state_e               w_state_nxt;
  logic [PROC_NUM-1:0]     w_in_dep;
  logic [PROC_NUM-1:0]     r_dep;
  logic [OUT_CHAN_NUM-1:0] r_vld;
  logic [OUT_CHAN_NUM-1:0] w_pick;
  logic                    r_self_det;
  logic                    r_token_held;
  logic                    w_blocked;
  logic                    w_self_hit;
  logic                    w_self_det_set;

  // OR of all upstream dependency slices currently marked valid
  always_comb begin
    w_in_dep = '0;
    for (int unsigned i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) begin
        w_in_dep = w_in_dep | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

  assign w_blocked  = |proc_dep_vld_vec;
  assign w_self_hit = w_blocked & w_in_dep[MY_PROC_ID];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_self_det_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dl_detect_in) begin
          w_state_nxt = ST_DL;
        end else if (w_blocked) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dl_detect_in || w_self_hit) begin
          w_state_nxt    = ST_DL;
          w_self_det_set = w_self_hit;
        end else if (!w_blocked) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DL:   w_state_nxt = ST_DL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dependency vector and valids track inputs until a deadlock freezes them
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dep        <= '0;
      r_vld        <= '0;
      r_self_det   <= 1'b0;
      r_token_held <= 1'b0;
    end else begin
      if (r_state != ST_DL) begin
        r_dep <= w_blocked ? (MY_BIT | w_in_dep) : '0;
        r_vld <= proc_dep_vld_vec;
      end
      if (w_self_det_set) begin
        r_self_det <= 1'b1;
      end
      if (r_state == ST_DL) begin
        if (token_clear) begin
          r_token_held <= 1'b0;
        end else if (origin || (|token_in_vec)) begin
          r_token_held <= 1'b1;
        end
      end
    end
  end

  aesl_deadlock_prio_pick #(
    .WIDTH (OUT_CHAN_NUM)
  ) u_pick (
    .vec    (r_vld),
    .onehot (w_pick)
  );

  assign out_chan_dep_data    = r_dep;
  assign out_chan_dep_vld_vec = r_vld;
  assign token_out_vec        = r_token_held ? w_pick : '0;
  assign dl_detect_out        = r_self_det | r_token_held;

endmodule

// File: doc/aesl_deadlock_detect_unit.md
AESL_DEADLOCK_DETECT_UNIT -- requirements
Module: AESL_deadlock_detect_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of dataflow processes, and the width of the dependency vectors.
REQ-002 SHALL have parameter MY_PROC_ID, default 0: index of the owning process; its one-hot bit is 1<<MY_PROC_ID.
REQ-003 SHALL have parameter IN_CHAN_NUM, default 1: number of upstream dependency channels.
REQ-004 SHALL have parameter OUT_CHAN_NUM, default 1: number of channels the owning process can block on.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on posedge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port proc_dep_vld_vec, input, OUT_CHAN_NUM bits: bit i high means the process is blocked on output channel i.
REQ-008 SHALL have port in_chan_dep_vld_vec, input, IN_CHAN_NUM bits: upstream dependency valid per channel.
REQ-009 SHALL have port in_chan_dep_data_vec, input, IN_CHAN_NUM*PROC_NUM bits: upstream dependency vectors; slice i is bits [i*PROC_NUM +: PROC_NUM].
REQ-010 SHALL have port token_in_vec, input, IN_CHAN_NUM bits: report token arriving from upstream.
REQ-011 SHALL have port dl_detect_in, input, 1 bit: global deadlock detected (OR of all units).
REQ-012 SHALL have port origin, input, 1 bit: one-cycle pulse from the report unit making this process the circle start.
REQ-013 SHALL have port token_clear, input, 1 bit: circle report finished; drop the token.
REQ-014 SHALL have port out_chan_dep_vld_vec, output, OUT_CHAN_NUM bits: dependency valid sent downstream.
REQ-015 SHALL have port out_chan_dep_data, output, PROC_NUM bits: accumulated dependency vector.
REQ-016 SHALL have port token_out_vec, output, OUT_CHAN_NUM bits: token forwarded downstream.
REQ-017 SHALL have port dl_detect_out, output, 1 bit: this process's bit of the report unit's dl_in_vec.

Function
REQ-018 SHALL implement FSM states ST_IDLE, ST_WAIT and ST_DL.
- blocked is defined as |proc_dep_vld_vec.
REQ-019 SHALL make these ST_IDLE transitions: blocked -> ST_WAIT; dl_detect_in -> ST_DL, with dl_detect_in taking priority.
REQ-020 SHALL make these ST_WAIT transitions: dl_detect_in or self_hit -> ST_DL; otherwise !blocked -> ST_IDLE.
- self_hit means: blocked AND some valid input slice has bit MY_PROC_ID set.
REQ-021 SHALL leave ST_DL only by reset, so ST_DL is terminal.
REQ-022 SHALL update dep_reg each cycle in ST_IDLE and ST_WAIT.
- Blocked: dep_reg <= (1<<MY_PROC_ID) | OR of the slices whose in_chan_dep_vld_vec bit is set.
- Not blocked: dep_reg <= 0.
REQ-023 SHALL register vld_reg <= proc_dep_vld_vec under the same condition as REQ-022.
- In ST_DL, dep_reg and vld_reg are frozen.
- Latency is one cycle per hop.
REQ-024 SHALL drive out_chan_dep_data = dep_reg and out_chan_dep_vld_vec = vld_reg.
REQ-025 SHALL set self_det <= 1 when the ST_WAIT->ST_DL transition is caused by self_hit; it stays 1 until reset.
REQ-026 SHALL update token_held only in ST_DL.
- Set when origin or |token_in_vec.
- Clear when token_clear; clear wins over a simultaneous set.
REQ-027 SHALL drive token_out_vec = token_held ? lowest-index set bit of vld_reg : 0 (combinational, one-hot or zero).
REQ-028 SHALL drive dl_detect_out = self_det | token_held, both registered, with no combinational input path.
REQ-029 SHALL ignore origin, token_in_vec and token_clear outside ST_DL.

Reset
REQ-030 SHALL clear state to ST_IDLE and dep_reg, vld_reg, self_det and token_held to 0 on reset low, asynchronously and at any time, including mid-ST_DL.
- All outputs are 0 during and immediately after reset.

Structure
REQ-031 SHALL place the FSM state encodings (2-bit) in shared package aesl_deadlock_pkg, which the report unit also uses.
REQ-032 SHALL implement the lowest-set-bit selection as sub-module aesl_deadlock_prio_pick (parameter WIDTH; input vec; output one-hot).

Verification (PROC_NUM=2, MY_PROC_ID=0, IN_CHAN_NUM=1, OUT_CHAN_NUM=1 unless stated)
REQ-033 SHALL cover: reset low for 3 cycles with random inputs -> all outputs 0 throughout.
REQ-034 SHALL cover: proc_dep_vld=1, in_vld=1, in_data=2'b10 -> next cycle out_data=2'b11 and out_vld=1; then in_data=2'b11 -> next cycle dl_detect_out=1, state ST_DL.
REQ-035 SHALL cover: in ST_WAIT with out_data=2'b11, drop proc_dep_vld -> next cycle out_data=0, out_vld=0, state ST_IDLE.
REQ-036 SHALL cover, after self-detect:
- origin pulse -> next cycle token_out_vec=1.
- token_clear together with token_in=1 -> next cycle token_out_vec=0 and dl_detect_out still 1 (self_det).
REQ-037 SHALL cover: dl_detect_in=1 with no self hit -> ST_DL, dl_detect_out=0; token_in=1 -> next cycle dl_detect_out=1; token_clear -> 0.
REQ-038 SHALL cover: OUT_CHAN_NUM=3, vld_reg=3'b110, token held -> token_out_vec=3'b010; reset mid-ST_DL -> immediate return to ST_IDLE with outputs 0.
